// File: rtl/bf_pkg.sv
// -----------------------------------------------------------------------------
// bf_pkg
// Shared definitions for the bf_core Brainfuck execution core:
//   - default parameter values (cell width, address widths, loop-stack depth)
//   - the controller state enumeration
//   - the ASCII opcode constants the core decodes
// Imported by bf_core and bf_loop_stack.
// -----------------------------------------------------------------------------
package bf_pkg;

    // Default build parameters
    localparam int BF_DATA_W_DEF      = 8;
    localparam int BF_DADDR_W_DEF     = 8;
    localparam int BF_IADDR_W_DEF     = 8;
    localparam int BF_STACK_DEPTH_DEF = 16;

    // Controller states
    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_SCAN     = 3'd1,
        ST_WAIT_IN  = 3'd2,
        ST_WAIT_OUT = 3'd3,
        ST_HALT     = 3'd4
    } bf_state_e;

    // ASCII opcodes
    localparam logic [7:0] OP_INC   = 8'h2B;  // '+'
    localparam logic [7:0] OP_DEC   = 8'h2D;  // '-'
    localparam logic [7:0] OP_LEFT  = 8'h3C;  // '<'
    localparam logic [7:0] OP_RIGHT = 8'h3E;  // '>'
    localparam logic [7:0] OP_LOOP  = 8'h5B;  // '['
    localparam logic [7:0] OP_END   = 8'h5D;  // ']'
    localparam logic [7:0] OP_OUT   = 8'h2E;  // '.'
    localparam logic [7:0] OP_IN    = 8'h2C;  // ','
    localparam logic [7:0] OP_HALT  = 8'h00;  // program terminator

endpackage

// File: rtl/bf_loop_stack.sv
// -----------------------------------------------------------------------------
// bf_loop_stack
// LIFO holding the instruction addresses of open '[' loops.
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset (empties the stack)
//   push       in   push push_data (ignored when full)
//   pop        in   discard top entry (ignored when empty)
//   push_data  in   W   address to push
//   top        out  W   most recently pushed entry (0 when empty)
//   full       out  all DEPTH entries in use
//   empty      out  no entries in use
// -----------------------------------------------------------------------------
module bf_loop_stack
    import bf_pkg::*;
#(
    parameter int DEPTH = BF_STACK_DEPTH_DEF,
    parameter int W     = BF_IADDR_W_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_idx_s;
    logic [AW-1:0] top_idx_s;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == {CW{1'b0}});

    // Entry indices derived from the occupancy count
    always_comb begin
        wr_idx_s  = AW'(count_q);
        top_idx_s = AW'(count_q - CW'(1'b1));
        if (empty) begin
            top = {W{1'b0}};
        end else begin
            top = mem_q[top_idx_s];
        end
    end

    // Next-state for storage and occupancy; push has priority over pop
    always_comb begin
        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push && !full) begin
            mem_d[wr_idx_s] = push_data;
            count_d         = count_q + CW'(1'b1);
        end else if (pop && !empty) begin
            count_d = count_q - CW'(1'b1);
        end else begin
            count_d = count_q;
        end
    end

    // Storage and occupancy registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: rtl/bf_core.sv
// -----------------------------------------------------------------------------
// bf_core
// Brainfuck execution core. Fetches ASCII opcodes from an external program
// memory and operates on an external data memory, one opcode per cycle in RUN.
// Optional feature macro: BF_DATA_WRAP_EN -- when defined the data pointer
// wraps at both ends; otherwise moving past either end halts with error.
// Ports:
//   clock                 in   rising-edge clock
//   reset                 in   asynchronous active-low reset
//   instptr / instr       out/in  instruction address / opcode (comb. read)
//   dataptr / data        out/in  data address / cell value (comb. read)
//   memval / memwrite     out  write value and strobe, written at next edge
//   in_data/in_valid/in_ready     input stream handshake
//   out_data/out_valid/out_ready  output stream handshake
//   halted / error        out  program finished or faulted / fault flag
// -----------------------------------------------------------------------------
module bf_core
    import bf_pkg::*;
#(
    parameter int DATA_W      = BF_DATA_W_DEF,
    parameter int DADDR_W     = BF_DADDR_W_DEF,
    parameter int IADDR_W     = BF_IADDR_W_DEF,
    parameter int STACK_DEPTH = BF_STACK_DEPTH_DEF
) (
    input  logic               clock,
    input  logic               reset,
    output logic [IADDR_W-1:0] instptr,
    input  logic [7:0]         instr,
    output logic [DADDR_W-1:0] dataptr,
    input  logic [DATA_W-1:0]  data,
    output logic [DATA_W-1:0]  memval,
    output logic               memwrite,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               halted,
    output logic               error
);

    localparam logic [IADDR_W:0] DEPTH_ONE = {{IADDR_W{1'b0}}, 1'b1};

    bf_state_e          state_q,   state_d;
    logic [IADDR_W-1:0] instptr_q, instptr_d;
    logic [DADDR_W-1:0] dataptr_q, dataptr_d;
    logic [IADDR_W:0]   depth_q,   depth_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               error_q,   error_d;

    logic [DATA_W-1:0]  memval_s;
    logic               memwrite_s;
    logic               adv_s;       // current instruction completes with instptr+1
    logic               at_last_s;   // instptr is the final program address
    logic               push_s;
    logic               pop_s;
    logic [IADDR_W-1:0] top_s;
    logic               full_s;
    logic               empty_s;

    bf_loop_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (IADDR_W)
    ) u_stack (
        .clock     (clock),
        .reset     (reset),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (instptr_q),
        .top       (top_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    assign at_last_s = (instptr_q == {IADDR_W{1'b1}});

    // Next-state, datapath and write-strobe decode
    always_comb begin
        state_d    = state_q;
        instptr_d  = instptr_q;
        dataptr_d  = dataptr_q;
        depth_d    = depth_q;
        out_data_d = out_data_q;
        error_d    = error_q;
        memval_s   = {DATA_W{1'b0}};
        memwrite_s = 1'b0;
        adv_s      = 1'b0;
        push_s     = 1'b0;
        pop_s      = 1'b0;

        case (state_q)
            ST_RUN: begin
                case (instr)
                    OP_INC: begin
                        memval_s   = data + DATA_W'(1'b1);
                        memwrite_s = 1'b1;
                        adv_s      = 1'b1;
                    end
                    OP_DEC: begin
                        memval_s   = data - DATA_W'(1'b1);
                        memwrite_s = 1'b1;
                        adv_s      = 1'b1;
                    end
                    OP_RIGHT: begin
`ifdef BF_DATA_WRAP_EN
                        dataptr_d = dataptr_q + DADDR_W'(1'b1);
                        adv_s     = 1'b1;
`else
                        if (dataptr_q == {DADDR_W{1'b1}}) begin
                            state_d = ST_HALT;
                            error_d = 1'b1;
                        end else begin
                            dataptr_d = dataptr_q + DADDR_W'(1'b1);
                            adv_s     = 1'b1;
                        end
`endif
                    end
                    OP_LEFT: begin
`ifdef BF_DATA_WRAP_EN
                        dataptr_d = dataptr_q - DADDR_W'(1'b1);
                        adv_s     = 1'b1;
`else
                        if (dataptr_q == {DADDR_W{1'b0}}) begin
                            state_d = ST_HALT;
                            error_d = 1'b1;
                        end else begin
                            dataptr_d = dataptr_q - DADDR_W'(1'b1);
                            adv_s     = 1'b1;
                        end
`endif
                    end
                    OP_IN: begin
                        state_d = ST_WAIT_IN;
                    end
                    OP_OUT: begin
                        // Capture now so the beat stays stable while stalled
                        out_data_d = data;
                        state_d    = ST_WAIT_OUT;
                    end
                    OP_LOOP: begin
                        if (data != {DATA_W{1'b0}}) begin
                            if (full_s) begin
                                state_d = ST_HALT;
                                error_d = 1'b1;
                            end else begin
                                push_s = 1'b1;
                                adv_s  = 1'b1;
                            end
                        end else begin
                            state_d = ST_SCAN;
                            depth_d = DEPTH_ONE;
                            adv_s   = 1'b1;
                        end
                    end
                    OP_END: begin
                        if (empty_s) begin
                            state_d = ST_HALT;
                            error_d = 1'b1;
                        end else if (data != {DATA_W{1'b0}}) begin
                            // Re-enter the body just past the matching '['
                            instptr_d = top_s + IADDR_W'(1'b1);
                        end else begin
                            pop_s = 1'b1;
                            adv_s = 1'b1;
                        end
                    end
                    OP_HALT: begin
                        state_d = ST_HALT;
                        error_d = 1'b0;
                    end
                    default: begin
                        adv_s = 1'b1;
                    end
                endcase
            end
            ST_SCAN: begin
                case (instr)
                    OP_HALT: begin
                        state_d = ST_HALT;
                        error_d = 1'b1;
                    end
                    OP_LOOP: begin
                        depth_d = depth_q + DEPTH_ONE;
                        adv_s   = 1'b1;
                    end
                    OP_END: begin
                        depth_d = depth_q - DEPTH_ONE;
                        adv_s   = 1'b1;
                        if (depth_q == DEPTH_ONE) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_SCAN;
                        end
                    end
                    default: begin
                        adv_s = 1'b1;
                    end
                endcase
            end
            ST_WAIT_IN: begin
                if (in_valid) begin
                    memval_s   = in_data;
                    memwrite_s = 1'b1;
                    state_d    = ST_RUN;
                    adv_s      = 1'b1;
                end else begin
                    state_d = ST_WAIT_IN;
                end
            end
            ST_WAIT_OUT: begin
                if (out_ready) begin
                    state_d = ST_RUN;
                    adv_s   = 1'b1;
                end else begin
                    state_d = ST_WAIT_OUT;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
                error_d = 1'b1;
            end
        endcase

        // Running off the end of program memory is a clean finish
        if (adv_s && at_last_s) begin
            state_d = ST_HALT;
            error_d = 1'b0;
        end else begin
            instptr_d = adv_s ? (instptr_q + IADDR_W'(1'b1)) : instptr_d;
        end
    end

    // Controller state and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            instptr_q  <= {IADDR_W{1'b0}};
            dataptr_q  <= {DADDR_W{1'b0}};
            depth_q    <= {(IADDR_W + 1){1'b0}};
            out_data_q <= {DATA_W{1'b0}};
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            instptr_q  <= instptr_d;
            dataptr_q  <= dataptr_d;
            depth_q    <= depth_d;
            out_data_q <= out_data_d;
            error_q    <= error_d;
        end
    end

    // The write strobe is decoded from the current opcode so the cell updates
    // at the same edge the instruction retires; reset masks it immediately.
    assign memwrite  = memwrite_s & reset;
    assign memval    = reset ? memval_s : {DATA_W{1'b0}};
    assign instptr   = instptr_q;
    assign dataptr   = dataptr_q;
    assign out_data  = out_data_q;
    assign in_ready  = (state_q == ST_WAIT_IN);
    assign out_valid = (state_q == ST_WAIT_OUT);
    assign halted    = (state_q == ST_HALT);
    assign error     = error_q;

endmodule

// File: doc/bf_core.md
BF_CORE -- requirements
Module: bf_core

Interface
REQ-001 Parameters SHALL be: DATA_W, default 8, cell width; DADDR_W, default 8, data address width; IADDR_W, default 8, instruction address width; STACK_DEPTH, default 16, loop-stack entries.
REQ-002 clock  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low; core is held in reset while low.
REQ-004 instptr  out  IADDR_W  instruction fetch address; instr  in  8  ASCII opcode, combinational read.
REQ-005 dataptr  out  DADDR_W  data address; data  in  DATA_W  cell value, combinational read.
REQ-006 memval  out  DATA_W  write value; memwrite  out  1  write strobe, written at the next rising edge.
REQ-007 in_data  in  DATA_W, in_valid  in  1, in_ready  out  1  input stream handshake.
REQ-008 out_data  out  DATA_W, out_valid  out  1, out_ready  in  1  output stream handshake.
REQ-009 halted  out  1  program finished or faulted; error  out  1  fault flag.

Function
REQ-010 States SHALL be RUN, SCAN, WAIT_IN, WAIT_OUT and HALT; RUN executes one opcode per cycle.
REQ-011 '+'/'-': memval = data +/- 1 modulo 2^DATA_W, memwrite high one cycle, instptr+1.
REQ-012 '>'/'<': dataptr +/- 1; boundary behaviour per REQ-024/025.
REQ-013 ',': enter WAIT_IN with in_ready high; on the in_valid&&in_ready cycle, memval = in_data, memwrite high, instptr+1, return to RUN.
REQ-014 '.': out_data = data latched, out_valid high in WAIT_OUT; out_data stable until out_valid&&out_ready, then instptr+1, RUN.
REQ-015 '[' with data != 0: push instptr onto loop stack, instptr+1; with data == 0: enter SCAN with depth=1.
REQ-016 SCAN: instptr+1 per cycle; '[' increments depth, ']' decrements; at depth 0 go to RUN at the address after the matching ']'.
REQ-017 ']' with data != 0: instptr = top+1 (no pop); with data == 0: pop, instptr+1.
REQ-018 Opcode 8'h00 SHALL enter HALT (halted=1, error=0); all other codes are one-cycle no-ops.
REQ-019 Push with stack full, or ']' with stack empty: HALT with error=1.
REQ-020 8'h00 encountered in SCAN: HALT with error=1.
REQ-021 Completing instruction at address 2^IADDR_W-1 without halt: HALT, error=0.
REQ-022 HALT is terminal until reset; memwrite, in_ready, out_valid SHALL be 0 in HALT.
REQ-023 memwrite SHALL never be high outside the cycles named in REQ-011/013.

Configuration
REQ-024 With BF_DATA_WRAP_EN defined, dataptr SHALL wrap modulo 2^DADDR_W at both ends.
REQ-025 Without BF_DATA_WRAP_EN, '>' at max or '<' at 0 SHALL HALT with error=1 and leave dataptr unchanged.

Reset
REQ-026 While reset is low: state RUN, instptr=0, dataptr=0, stack empty, depth=0, memval=0, memwrite=0, in_ready=0, out_valid=0, out_data=0, halted=0, error=0.
REQ-027 Reset asserted mid-operation, including WAIT_OUT and SCAN, SHALL abort immediately with no further write; execution restarts at address 0 on the first edge after release.

Structure
REQ-028 Package bf_pkg SHALL hold the state enum, opcode constants ('+','-','<','>','[',']','.',',',8'h00) and the default parameter values.
REQ-029 The loop stack SHALL be sub-module bf_loop_stack: STACK_DEPTH x IADDR_W entries, push, pop, top, full, empty outputs.

Verification
REQ-030 "+++." with out_ready=1 -> one out_valid beat, out_data=3, then halted=1, error=0.
REQ-031 "++[->+<]>." -> output 2, cell 0 = 0, cell 1 = 2.
REQ-032 "[+++]." with cell 0 = 0 -> SCAN skips the loop body, output 0, no memwrite before output.
REQ-033 ",." with in_valid delayed 5 cycles, in_data=8'hA5, out_ready low 3 cycles -> in_ready high throughout the wait, output A5 held stable until accepted.
REQ-034 STACK_DEPTH=2 running "[[[" on cell value 1 -> error=1 at the third '['; "]" alone on cell value 1 -> error=1.
REQ-035 "<." without BF_DATA_WRAP_EN -> error=1, dataptr=0; with BF_DATA_WRAP_EN -> dataptr=255, output equals cell 255; reset pulsed during WAIT_OUT -> out_valid=0 and restart at address 0.
